// File: rtl/prog_loader.sv
// Framed byte-stream loader: assembles little-endian words from UART bytes,
// writes them to instruction RAM and releases the core once the checksum matches.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | no frame seen since reset; waiting for SYNC_BYTE
// S_LEN0  | waiting for low byte of the word count
// S_LEN1  | waiting for high byte of the word count
// S_DATA  | assembling data bytes into words and writing them
// S_CSUM  | waiting for the checksum byte
// S_DONE  | frame accepted, core released; SYNC_BYTE starts a reload
// S_ERROR | frame rejected, core held; SYNC_BYTE starts a reload
module prog_loader #(
    parameter int         DATA_W         = 32,
    parameter int         ADDR_W         = 14,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_dv_i,
    input  logic [7:0]        rx_byte_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              reset_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);
    localparam int BPW = DATA_W / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [BCW-1:0] BYTE_LAST = BCW'(BPW - 1);
    localparam logic [TW-1:0]  TMO       = TW'(TIMEOUT_CYCLES);
    localparam logic [16:0]    DEPTH     = 17'(2 ** ADDR_W);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       last_q, last_d;
    logic [15:0]       idx_q, idx_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [BCW-1:0]    bcnt_q, bcnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [15:0]       len_n;
    logic [DATA_W-1:0] asm_next;
    logic              timeout_hit;

    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        last_d      = last_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        bcnt_d      = bcnt_q;
        csum_d      = csum_q;
        timer_d     = timer_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_code_d  = err_code_q;

        len_n       = {rx_byte_i, len_lo_q};
        // newest byte enters at the top so the first byte ends up in bits [7:0]
        asm_next    = (asm_q >> 8) | (DATA_W'(rx_byte_i) << (DATA_W - 8));
        timeout_hit = (TIMEOUT_CYCLES != 0) && busy_o && !rx_dv_i && (timer_q == TMO);

        if (!busy_o || rx_dv_i) begin
            timer_d = '0;
        end else if (timer_q != TMO) begin
            timer_d = timer_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (rx_dv_i && (rx_byte_i == SYNC_BYTE)) begin
                    state_d    = S_LEN0;
                    err_code_d = ERR_NONE;
                    csum_d     = '0;
                    idx_d      = '0;
                    bcnt_d     = '0;
                    asm_d      = '0;
                end
            end
            S_LEN0: begin
                if (rx_dv_i) begin
                    len_lo_d = rx_byte_i;
                    csum_d   = csum_q + rx_byte_i;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (rx_dv_i) begin
                    csum_d = csum_q + rx_byte_i;
                    last_d = len_n - 1'b1;
                    if ({1'b0, len_n} > DEPTH) begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_LEN;
                    end else if (len_n == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_dv_i) begin
                    csum_d = csum_q + rx_byte_i;
                    asm_d  = asm_next;
                    if (bcnt_q == BYTE_LAST) begin
                        bcnt_d  = '0;
                        we_d    = 1'b1;
                        addr_d  = idx_q[ADDR_W-1:0];
                        wdata_d = asm_next;
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == last_q) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            S_CSUM: begin
                if (rx_dv_i) begin
                    if (rx_byte_i == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_CSUM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // only reachable without a byte, so it never competes with the case above
        if (timeout_hit) begin
            state_d    = S_ERROR;
            err_code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            len_lo_q   <= '0;
            last_q     <= '0;
            idx_q      <= '0;
            asm_q      <= '0;
            bcnt_q     <= '0;
            csum_q     <= '0;
            timer_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            asm_q      <= asm_d;
            bcnt_q     <= bcnt_d;
            csum_q     <= csum_d;
            timer_q    <= timer_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_code_q <= err_code_d;
        end
    end

    assign we_o       = we_q;
    assign addr_o     = addr_q;
    assign wdata_o    = wdata_q;
    assign busy_o     = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                        (state_q == S_DATA) || (state_q == S_CSUM);
    assign reset_o    = (state_q == S_DONE);
    assign done_o     = (state_q == S_DONE);
    assign err_o      = (state_q == S_ERROR);
    assign err_code_o = err_code_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a frame-level model tracked per byte position, compared
// against the DUT on every cycle, plus literal expectations for each scenario.
module tb_prog_loader;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int TMO    = 100;
    localparam int BPW    = DATA_W / 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              rx_dv;
    logic [7:0]        rx_byte;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        code;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    prog_loader #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .rx_dv_i(rx_dv),
        .rx_byte_i(rx_byte),
        .we_o(we),
        .addr_o(addr),
        .wdata_o(wdata),
        .reset_o(core_rst),
        .busy_o(busy),
        .done_o(done),
        .err_o(err),
        .err_code_o(code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (frame position based) ----------------
    bit                m_in    = 1'b0;
    int                m_pos   = 0;
    int                m_n     = 0;
    int                m_idle  = 0;
    int                m_d     = 0;
    logic [7:0]        m_lo    = '0;
    logic [7:0]        m_sum   = '0;
    logic [31:0]       m_acc   = '0;
    logic              m_we    = 1'b0;
    logic              m_done  = 1'b0;
    logic              m_err   = 1'b0;
    logic [1:0]        m_code  = '0;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [31:0]       m_wdata = '0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];

    always @(posedge clk) begin
        if (we === 1'b1) begin
            wr_addr.push_back(addr);
            wr_data.push_back(wdata);
        end
        cyc++;
        m_we = 1'b0;
        if (!rst_n) begin
            m_in = 1'b0; m_done = 1'b0; m_err = 1'b0; m_code = 2'd0;
            m_addr = '0; m_wdata = '0; m_idle = 0;
        end else if (!m_in) begin
            if (rx_dv && rx_byte == 8'hA5) begin
                m_in = 1'b1; m_pos = 0; m_sum = 8'd0; m_idle = 0;
                m_done = 1'b0; m_err = 1'b0; m_code = 2'd0;
            end
        end else if (rx_dv) begin
            m_idle = 0;
            if (m_pos == 0) begin
                m_lo = rx_byte; m_sum = m_sum + rx_byte; m_pos = 1;
            end else if (m_pos == 1) begin
                m_n = m_lo + 256 * rx_byte;
                m_sum = m_sum + rx_byte; m_pos = 2;
                if (m_n > DEPTH) begin
                    m_in = 1'b0; m_err = 1'b1; m_code = 2'd2;
                end
            end else if (m_pos < 2 + m_n * BPW) begin
                m_d = m_pos - 2;
                m_acc[8*(m_d % BPW) +: 8] = rx_byte;
                m_sum = m_sum + rx_byte;
                m_pos++;
                if (m_d % BPW == BPW - 1) begin
                    m_we = 1'b1; m_addr = ADDR_W'(m_d / BPW); m_wdata = m_acc;
                end
            end else begin
                m_in = 1'b0;
                if (rx_byte == m_sum) m_done = 1'b1;
                else begin m_err = 1'b1; m_code = 2'd1; end
            end
        end else if (m_idle == TMO) begin
            m_in = 1'b0; m_err = 1'b1; m_code = 2'd3;
        end else begin
            m_idle++;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("cyc we_o", we, m_we);
            chk("cyc addr_o", addr, m_addr);
            chk("cyc wdata_o", wdata, m_wdata);
            chk("cyc reset_o", core_rst, m_done);
            chk("cyc busy_o", busy, m_in);
            chk("cyc done_o", done, m_done);
            chk("cyc err_o", err, m_err);
            chk("cyc err_code_o", code, m_code);
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] fq[$];

    task automatic send_byte(input logic [7:0] b);
        rx_dv = 1'b1; rx_byte = b;
        @(negedge clk);
        rx_dv = 1'b0;
    endtask

    task automatic send_fq();
        foreach (fq[i]) begin
            send_byte(fq[i]);
            @(negedge clk);
        end
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic chk_write(input string name, input int i, input logic [ADDR_W-1:0] a,
                             input logic [31:0] d);
        if (wr_addr.size() > i) begin
            chk({name, " addr"}, wr_addr[i], a);
            chk({name, " data"}, wr_data[i], d);
        end else begin
            chk({name, " missing write"}, 64'(wr_addr.size()), 64'(i + 1));
        end
    endtask

    task automatic good_frame();
        fq = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4E};
        send_fq();
    endtask

    initial begin
        rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
        @(negedge clk);
        send_byte(8'hA5);           // ignored during reset
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset busy", busy, 1'b0);
        chk("reset reset_o", core_rst, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset err", err, 1'b0);
        chk("reset addr", addr, 8'h00);
        chk("reset wdata", wdata, 32'h0);
        repeat (2) @(negedge clk);

        // 1: good frame
        clear_writes();
        good_frame();
        chk("t1 write count", 64'(wr_addr.size()), 64'd2);
        chk_write("t1 w0", 0, 8'd0, 32'h12345678);
        chk_write("t1 w1", 1, 8'd1, 32'hDEADBEEF);
        chk("t1 reset_o", core_rst, 1'b1);
        chk("t1 done", done, 1'b1);
        chk("t1 code", code, 2'd0);

        // 2: bad checksum, then recovery
        clear_writes();
        fq = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4F};
        send_fq();
        chk("t2 write count", 64'(wr_addr.size()), 64'd2);
        chk_write("t2 w1", 1, 8'd1, 32'hDEADBEEF);
        chk("t2 err", err, 1'b1);
        chk("t2 code", code, 2'd1);
        chk("t2 reset_o", core_rst, 1'b0);
        good_frame();
        chk("t2 recover done", done, 1'b1);

        // 3: length check and empty frame
        clear_writes();
        fq = '{8'hA5, 8'h01, 8'h01};
        send_fq();
        chk("t3 err", err, 1'b1);
        chk("t3 code", code, 2'd2);
        chk("t3 busy", busy, 1'b0);
        fq = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_fq();
        chk("t3 empty done", done, 1'b1);
        chk("t3 write count", 64'(wr_addr.size()), 64'd0);

        // 4: timeout; a byte landing on the expiry cycle wins
        clear_writes();
        fq = '{8'hA5, 8'h01, 8'h00, 8'h11};
        send_fq();
        repeat (TMO - 1) @(negedge clk);
        send_byte(8'h22);
        @(negedge clk);
        chk("t4 byte wins busy", busy, 1'b1);
        chk("t4 byte wins err", err, 1'b0);
        send_byte(8'h33);
        @(negedge clk);
        repeat (TMO - 1) @(negedge clk);
        chk("t4 before expiry err", err, 1'b0);
        @(negedge clk);
        chk("t4 expiry err", err, 1'b1);
        chk("t4 expiry code", code, 2'd3);
        chk("t4 expiry busy", busy, 1'b0);
        chk("t4 write count", 64'(wr_addr.size()), 64'd0);

        // 5: reload from DONE; SYNC value inside data is plain data
        good_frame();
        clear_writes();
        send_byte(8'hA5);
        chk("t5 reset_o falls", core_rst, 1'b0);
        chk("t5 done clears", done, 1'b0);
        chk("t5 busy", busy, 1'b1);
        @(negedge clk);
        fq = '{8'h01, 8'h00, 8'hA5, 8'hBB, 8'hCC, 8'hDD, 8'h0A};
        send_fq();
        chk("t5 write count", 64'(wr_addr.size()), 64'd1);
        chk_write("t5 w0", 0, 8'd0, 32'hDDCCBBA5);
        chk("t5 done", done, 1'b1);

        // 6: reset mid-DATA
        clear_writes();
        fq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_fq();
        rst_n = 1'b0; rx_dv = 1'b1; rx_byte = 8'h33;
        @(negedge clk);
        rst_n = 1'b1; rx_dv = 1'b0;
        chk("t6 busy", busy, 1'b0);
        chk("t6 we", we, 1'b0);
        chk("t6 addr", addr, 8'h00);
        chk("t6 wdata", wdata, 32'h0);
        chk("t6 reset_o", core_rst, 1'b0);
        chk("t6 code", code, 2'd0);
        repeat (3) @(negedge clk);
        fq = '{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAB};
        send_fq();
        chk("t6 write count", 64'(wr_addr.size()), 64'd1);
        chk_write("t6 w0", 0, 8'd0, 32'h11223344);
        chk("t6 done", done, 1'b1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of stimulus, expected completion before 100000");
        $fatal(1);
    end

endmodule
